// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter/rotator, one register stage per shift level, valid/ready on both sides.
// Rotate modes are built only when PIPE_BARREL_SHIFTER_ROTATE_EN is defined; otherwise ROL/ROR pass through.
`timescale 1ns/1ps
module pipe_barrel_shifter #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
`ifdef PIPE_BARREL_SHIFTER_ROTATE_EN
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;
`endif

  // One shift level: amt is the stage's fixed power of two, en its shamt bit.
  function automatic logic [WIDTH-1:0] shift_stage(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       op,
    input logic             sign,
    input logic             en,
    input int               amt
  );
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] fill;
    fill = ~({WIDTH{1'b1}} >> amt);
    if (en) begin
      case (op)
        OP_SLL:  r = d << amt;
        OP_SRL:  r = d >> amt;
        OP_SRA:  r = (d >> amt) | (sign ? fill : {WIDTH{1'b0}});
`ifdef PIPE_BARREL_SHIFTER_ROTATE_EN
        OP_ROL:  r = (d << amt) | (d >> (WIDTH - amt));
        OP_ROR:  r = (d >> amt) | (d << (WIDTH - amt));
`endif
        default: r = d;
      endcase
    end else begin
      r = d;
    end
    return r;
  endfunction

  logic             valid_r [SHW];
  logic [2:0]       op_r    [SHW];
  logic [SHW-1:0]   shamt_r [SHW];
  logic [WIDTH-1:0] data_r  [SHW];
  logic             sign_r  [SHW];

  logic             src_valid_s [SHW];
  logic [2:0]       src_op_s    [SHW];
  logic [SHW-1:0]   src_shamt_s [SHW];
  logic [WIDTH-1:0] src_data_s  [SHW];
  logic             src_sign_s  [SHW];
  logic [WIDTH-1:0] nxt_data_s  [SHW];

  logic advance_s;

  assign out_valid = valid_r[SHW-1];
  assign advance_s = !out_valid || out_ready;
  assign in_ready  = advance_s && !flush;
  // Output is gated so stale data left behind by a flush never shows.
  assign out_data  = out_valid ? data_r[SHW-1] : {WIDTH{1'b0}};
  assign out_zero  = out_valid && (data_r[SHW-1] == {WIDTH{1'b0}});

  // Stage inputs and the shifted data each stage would load.
  always_comb begin
    src_valid_s[0] = in_valid && in_ready;
    src_op_s[0]    = in_op;
    src_shamt_s[0] = in_shamt;
    src_data_s[0]  = in_data;
    src_sign_s[0]  = in_data[WIDTH-1];
    for (int k = 1; k < SHW; k++) begin
      src_valid_s[k] = valid_r[k-1];
      src_op_s[k]    = op_r[k-1];
      src_shamt_s[k] = shamt_r[k-1];
      src_data_s[k]  = data_r[k-1];
      src_sign_s[k]  = sign_r[k-1];
    end
    for (int k = 0; k < SHW; k++) begin
      nxt_data_s[k] = shift_stage(src_data_s[k], src_op_s[k], src_sign_s[k],
                                  src_shamt_s[k][k], 32'd1 << k);
    end
  end

  // Pipeline registers: global stall, flush kills valids only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SHW; k++) begin
        valid_r[k] <= 1'b0;
        op_r[k]    <= 3'b000;
        shamt_r[k] <= {SHW{1'b0}};
        data_r[k]  <= {WIDTH{1'b0}};
        sign_r[k]  <= 1'b0;
      end
    end else if (flush) begin
      for (int k = 0; k < SHW; k++) begin
        valid_r[k] <= 1'b0;
      end
    end else if (advance_s) begin
      for (int k = 0; k < SHW; k++) begin
        valid_r[k] <= src_valid_s[k];
        op_r[k]    <= src_op_s[k];
        shamt_r[k] <= src_shamt_s[k];
        data_r[k]  <= nxt_data_s[k];
        sign_r[k]  <= src_sign_s[k];
      end
    end else begin
      for (int k = 0; k < SHW; k++) begin
        valid_r[k] <= valid_r[k];
      end
    end
  end

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Self-checking bench for pipe_barrel_shifter (WIDTH 8): directed cases plus random traffic
// against a queue-based reference model; honours PIPE_BARREL_SHIFTER_ROTATE_EN.
`timescale 1ns/1ps
module tb_pipe_barrel_shifter;

  localparam int W = 8;
  localparam int S = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_op = 3'b000;
  logic [S-1:0] in_shamt = 3'd0;
  logic [W-1:0] in_data = 8'h00;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_zero;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  pipe_barrel_shifter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_shamt(in_shamt), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result from the operation definitions, using doubled words for rotates.
  function automatic logic [7:0] model(input logic [2:0] op, input logic [2:0] sh, input logic [7:0] d);
    logic signed [7:0] sd;
    logic [15:0] t;
    sd = d;
    case (op)
      3'd0: begin t = {8'h00, d} << sh; model = t[7:0]; end
      3'd1: model = d >> sh;
      3'd2: model = sd >>> sh;
`ifdef PIPE_BARREL_SHIFTER_ROTATE_EN
      3'd3: begin t = {d, d} << sh; model = t[15:8]; end
      3'd4: begin t = {d, d} >> sh; model = t[7:0]; end
`endif
      default: model = d;
    endcase
  endfunction

  // Scoreboard: outputs are sampled on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      check_value("zero_flag", out_zero, out_valid && (out_data == 8'h00));
      if (!out_valid) check_value("gated_data", out_data, 8'h00);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_value("spurious_result", 32'd1, 32'd0);
        else check_value("result", out_data, exp_q.pop_front());
      end
      if (flush) exp_q.delete();
      if (in_valid && in_ready) exp_q.push_back(model(in_op, in_shamt, in_data));
    end
  end

  task automatic drive(input logic v, input logic [2:0] op, input logic [2:0] sh, input logic [7:0] d);
    in_valid = v; in_op = op; in_shamt = sh; in_data = d;
  endtask

  // One isolated op on an empty pipeline; checks exact 3-cycle latency.
  task automatic run_one(input string tag, input logic [2:0] op, input logic [2:0] sh,
                         input logic [7:0] d, input logic [7:0] exp);
    drive(1'b1, op, sh, d);
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1; check_value({tag, "_early"}, out_valid, 1'b0);
    @(posedge clk); #1;
    check_value({tag, "_valid"}, out_valid, 1'b1);
    check_value({tag, "_data"}, out_data, exp);
    check_value({tag, "_zero"}, out_zero, exp == 8'h00);
    @(posedge clk); #1;
  endtask

  logic [7:0] exp_rol, exp_ror;

  initial begin
`ifdef PIPE_BARREL_SHIFTER_ROTATE_EN
    exp_rol = 8'h03; exp_ror = 8'hC0;
`else
    exp_rol = 8'h81; exp_ror = 8'h81;
`endif
    #1;
    check_value("rst_out_valid", out_valid, 1'b0);
    check_value("rst_out_data", out_data, 8'h00);
    check_value("rst_out_zero", out_zero, 1'b0);
    @(posedge clk); #3; rst = 1'b0;
    @(posedge clk); #1;
    check_value("rst_in_ready", in_ready, 1'b1);

    run_one("sll", 3'd0, 3'd3, 8'hB3, 8'h98);
    run_one("sra", 3'd2, 3'd5, 8'h96, 8'hFC);
    run_one("srl", 3'd1, 3'd5, 8'h96, 8'h04);
    run_one("srl_zero", 3'd1, 3'd1, 8'h01, 8'h00);
    run_one("rol", 3'd3, 3'd1, 8'h81, exp_rol);
    run_one("ror", 3'd4, 3'd1, 8'h81, exp_ror);
    run_one("pass", 3'd7, 3'd4, 8'h81, 8'h81);
    run_one("sra_sh0", 3'd2, 3'd0, 8'hA5, 8'hA5);

    // Backpressure: four SLLs of 8'h01, then two stalled cycles.
    drive(1'b1, 3'd0, 3'd0, 8'h01);
    @(posedge clk); #1; in_shamt = 3'd1;
    @(posedge clk); #1; in_shamt = 3'd2;
    @(posedge clk); #1; in_shamt = 3'd3;
    check_value("bp_first_valid", out_valid, 1'b1);
    check_value("bp_first_data", out_data, 8'h01);
    out_ready = 1'b0; #1;
    check_value("bp_in_ready_stall", in_ready, 1'b0);
    @(posedge clk); #1;
    check_value("bp_hold1", out_data, 8'h01);
    check_value("bp_in_ready_stall2", in_ready, 1'b0);
    @(posedge clk); #1;
    check_value("bp_hold2", out_data, 8'h01);
    out_ready = 1'b1; #1;
    check_value("bp_in_ready_resume", in_ready, 1'b1);
    @(posedge clk); #1; in_valid = 1'b0;
    check_value("bp_r1", out_data, 8'h02);
    @(posedge clk); #1; check_value("bp_r2", out_data, 8'h04);
    @(posedge clk); #1; check_value("bp_r3", out_data, 8'h08);
    @(posedge clk); #1; check_value("bp_empty", out_valid, 1'b0);

    // Flush with two ops in flight and a third presented.
    drive(1'b1, 3'd0, 3'd1, 8'h11);
    @(posedge clk); #1; drive(1'b1, 3'd1, 3'd2, 8'hF0);
    @(posedge clk); #1; drive(1'b1, 3'd7, 3'd0, 8'h5A); flush = 1'b1; #1;
    check_value("flush_in_ready", in_ready, 1'b0);
    @(posedge clk); #1; flush = 1'b0;
    check_value("flush_killed0", out_valid, 1'b0);
    drive(1'b1, 3'd0, 3'd2, 8'h33);
    @(posedge clk); #1; in_valid = 1'b0;
    check_value("flush_killed1", out_valid, 1'b0);
    @(posedge clk); #1; check_value("flush_killed2", out_valid, 1'b0);
    @(posedge clk); #1;
    check_value("flush_next_valid", out_valid, 1'b1);
    check_value("flush_next_data", out_data, 8'hCC);
    @(posedge clk); #1;

    // Asynchronous reset with three ops in flight.
    drive(1'b1, 3'd7, 3'd0, 8'hFF);
    @(posedge clk); #1; in_data = 8'hEE;
    @(posedge clk); #1; in_data = 8'hDD;
    @(posedge clk); #1; in_valid = 1'b0;
    check_value("pre_rst_valid", out_valid, 1'b1);
    #2; rst = 1'b1; #1;
    check_value("async_rst_valid", out_valid, 1'b0);
    check_value("async_rst_data", out_data, 8'h00);
    check_value("async_rst_zero", out_zero, 1'b0);
    @(posedge clk); #3; rst = 1'b0;
    @(posedge clk); #1;
    check_value("post_rst_in_ready", in_ready, 1'b1);
    check_value("post_rst_valid", out_valid, 1'b0);

    // Random traffic with backpressure and occasional flush.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            8'($urandom));
      out_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 99) < 3);
      @(posedge clk); #1;
    end
    drive(1'b0, 3'd0, 3'd0, 8'h00);
    flush = 1'b0; out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check_value("drain_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
